// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Bundles the request, MTHI/MTLO and result signals of the MIPS
//   multiply/divide unit. The master modport is used by the issuing
//   control/datapath side, the slave modport by mul_div_unit itself.
//
//   start  : begin an operation (sampled only while busy=0)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a  : rs value (multiplicand / dividend)
//   src_b  : rt value (multiplier / divisor)
//   hi_we  : MTHI write enable
//   lo_we  : MTLO write enable
//   wdata  : MTHI/MTLO data
//   busy   : operation in progress
//   done   : one-cycle pulse when an operation updates HI/LO
//   hi, lo : architectural HI/LO registers
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit with the architectural HI/LO registers.
//   Executes MULT/MULTU (unsigned shift-add on operand magnitudes) and
//   DIV/DIVU (restoring division on magnitudes), one bit per cycle, plus
//   MTHI/MTLO writes while idle.
//
//   Ports:
//     clk   : clock, all state changes on posedge
//     rstn  : asynchronous active-low reset
//     bus   : mul_div_unit_if.slave (start/op/src_a/src_b/hi_we/lo_we/wdata
//             in, busy/done/hi/lo out)
//
//   Timing: start accepted at edge E0, ITER iteration edges (E1..E32),
//   sign fix and HI/LO write at E33 with done high the following cycle.
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic             clk,
    input  logic             rstn,
    mul_div_unit_if.slave    bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_div;     // latched op[1]
    logic                sign_q;     // negate product / quotient
    logic                sign_r;     // negate remainder
    logic                div_zero;   // divisor was zero
    logic [XLEN-1:0]     raw_a;      // unmodified dividend for divide-by-zero
    logic [XLEN-1:0]     opd;        // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0]   acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     hi_r;
    logic [XLEN-1:0]     lo_r;
    logic                done_r;

    // Conditional two's-complement negation helpers.
    function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    // Operand decode at acceptance: signed ops use magnitudes plus sign flags.
    logic                    op_signed;
    logic signed [XLEN-1:0]  a_s;
    logic signed [XLEN-1:0]  b_s;
    logic                    sa_in;
    logic                    sb_in;
    logic [XLEN-1:0]         mag_a_in;
    logic [XLEN-1:0]         mag_b_in;

    always_comb begin
        op_signed = ~bus.op[0];
        a_s       = $signed(bus.src_a);
        b_s       = $signed(bus.src_b);
        sa_in     = op_signed & (a_s < 0);
        sb_in     = op_signed & (b_s < 0);
        mag_a_in  = cneg_x(bus.src_a, sa_in);
        mag_b_in  = cneg_x(bus.src_b, sb_in);
    end

    // One iteration of each algorithm.
    logic [XLEN:0]       sum_m;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   mul_next;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        // Shift-add: add multiplicand to the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right,
        // pulling the carry in at the top.
        sum_m    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd};
        mul_next = acc[0] ? {sum_m, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        // Restoring division: the shifted remainder needs XLEN+1 bits since
        // the remainder can be as large as divisor-1 before shifting.
        trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        div_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= '0;
            opd      <= '0;
            acc      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // start has priority over a same-cycle MTHI/MTLO
                        is_div   <= bus.op[1];
                        sign_q   <= sa_in ^ sb_in;
                        sign_r   <= sa_in;
                        div_zero <= (bus.src_b == '0);
                        raw_a    <= bus.src_a;
                        opd      <= bus.op[1] ? mag_b_in : mag_a_in;
                        acc      <= bus.op[1] ? {{XLEN{1'b0}}, mag_a_in}
                                              : {{XLEN{1'b0}}, mag_b_in};
                        cnt      <= '0;
                        state    <= CALC;
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi_r, lo_r} <= cneg_2x(acc, sign_q);
                    end else if (div_zero) begin
                        // Divide by zero: defined result, no sign handling.
                        lo_r <= '1;
                        hi_r <= raw_a;
                    end else begin
                        lo_r <= cneg_x(acc[XLEN-1:0], sign_q);
                        hi_r <= cneg_x(acc[2*XLEN-1:XLEN], sign_r);
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit: directed cases, busy interlocks,
//   MTHI/MTLO, reset mid-operation and randomized operations against an
//   arithmetic reference model.
module tb_mul_div_unit;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        res = '0;
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = 64'(ua * ub);
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = ua / ub;
                        r = ua % ub;
                    end
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Issue one operation and check latency, result, done width and the
    // HI/LO hold during CALC. 'interfere' pulses start + MTHI mid-operation;
    // 'wr_same' asserts MTHI/MTLO in the start cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere, input bit wr_same);
        int n;
        int extra;
        logic [63:0] r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.hi_we = wr_same;
        bus.lo_we = wr_same;
        bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        n = 0;
        while (!bus.done && n < 60) begin
            if (interfere && n == 5) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.src_a = 32'h1111_2222;
                bus.src_b = 32'h0000_0003;
                bus.hi_we = 1'b1;
                bus.wdata = 32'hDEADBEEF;
            end else begin
                idle_inputs();
            end
            if (n == 10) begin
                chk("hold_hi", {32'd0, bus.hi}, {32'd0, exp_hi});
                chk("hold_lo", {32'd0, bus.lo}, {32'd0, exp_lo});
            end
            @(posedge clk);
            #1;
            n++;
        end
        idle_inputs();
        chk("latency", 64'(n), 64'd33);
        chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
        r = model(op, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk("hi", {32'd0, bus.hi}, {32'd0, exp_hi});
        chk("lo", {32'd0, bus.lo}, {32'd0, exp_lo});
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        chk("single_done", 64'(extra), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          dcnt;
        n_tests = 0;
        n_fail  = 0;
        exp_hi  = '0;
        exp_lo  = '0;
        rstn    = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.wdata = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi",   {32'd0, bus.hi}, 64'd0);
        chk("rst_lo",   {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed arithmetic cases
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_neg", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("multu_max", {bus.hi, bus.lo}, {32'hFFFFFFFE, 32'h00000001});
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
        do_op(2'b11, 32'h12345678, 32'd0, 1'b0, 1'b0);
        chk("divu_zero", {bus.hi, bus.lo}, {32'h12345678, 32'hFFFFFFFF});
        do_op(2'b10, 32'h87654321, 32'd0, 1'b0, 1'b0);
        chk("div_zero", {bus.hi, bus.lo}, {32'h87654321, 32'hFFFFFFFF});
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("div_ovf", {bus.hi, bus.lo}, {32'h00000000, 32'h80000000});

        // Busy interlock: mid-operation start and MTHI are ignored
        do_op(2'b01, 32'd1000, 32'd3000, 1'b1, 1'b0);
        chk("interlock", {bus.hi, bus.lo}, {32'd0, 32'd3000000});

        // Idle MTHI/MTLO
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mthi", {32'd0, bus.hi}, {32'd0, 32'hA5A5A5A5});
        chk("mtlo", {32'd0, bus.lo}, {32'd0, 32'hA5A5A5A5});
        chk("mt_done", {63'd0, bus.done}, 64'd0);
        exp_hi = 32'hA5A5A5A5;
        exp_lo = 32'hA5A5A5A5;

        // start wins over a same-cycle write
        do_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);
        chk("start_wins", {bus.hi, bus.lo}, {32'd0, 32'd6});

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 100));
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 1'b0, 1'b0);
        end

        // Reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'h0001_0001;
        bus.src_b = 32'h0000_0100;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
        chk("mid_rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("mid_rst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        chk("mid_rst_no_done", 64'(dcnt), 64'd0);
        chk("mid_rst_hold", {bus.hi, bus.lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
